// File: rtl/uart_tx_tick.sv
// uart_tx_tick: UART transmitter paced by an external one-clock baud strobe.
// Frame = start, DATA_BITS data (LSB first), optional parity, STOP_BITS stop.
// The line sits high in SYNC until the first tick after acceptance, so the
// start bit always lasts one full tick period.
//
// state  | meaning
// IDLE   | line high, ready for a byte
// SYNC   | byte latched, line high, waiting for the first tick
// START  | driving the start bit (low)
// DATA   | driving data bits, LSB first
// PARITY | driving the parity bit
// STOP   | driving stop bit(s) (high)
module uart_tx_tick #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int             CNT_W     = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
  localparam logic           HAS_PAR   = (PARITY_EN != 0);
  localparam logic           ODD_INV   = (PARITY_ODD != 0);
  localparam logic           LAST_STOP = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [CNT_W-1:0]     bit_cnt_q;
  logic                 stop_cnt_q;
  logic                 parity_q;
  logic                 tx_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 done_q;

  // Frame sequencer; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          // Ticks are ignored here, so a tick coinciding with acceptance
          // is never seen by SYNC.
          if (tx_valid && ready_q) begin
            shift_q  <= tx_data;
            parity_q <= (^tx_data) ^ ODD_INV;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= S_SYNC;
          end
        end
        S_SYNC: begin
          if (baud_tick) begin
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (baud_tick) begin
            tx_q      <= shift_q[0];
            bit_cnt_q <= '0;
            state_q   <= S_DATA;
          end
        end
        S_DATA: begin
          if (baud_tick) begin
            if (bit_cnt_q < LAST_BIT) begin
              shift_q   <= {1'b0, shift_q[DATA_BITS-1:1]};
              tx_q      <= shift_q[1];
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end else if (HAS_PAR) begin
              tx_q    <= parity_q;
              state_q <= S_PARITY;
            end else begin
              tx_q       <= 1'b1;
              stop_cnt_q <= 1'b0;
              state_q    <= S_STOP;
            end
          end
        end
        S_PARITY: begin
          if (baud_tick) begin
            tx_q       <= 1'b1;
            stop_cnt_q <= 1'b0;
            state_q    <= S_STOP;
          end
        end
        S_STOP: begin
          if (baud_tick) begin
            if (stop_cnt_q == LAST_STOP) begin
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              stop_cnt_q <= 1'b1;
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign tx       = tx_q;
  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule
